// File: rtl/trigger_sched_pkg.sv
// Shared defaults, types and a round-robin helper for the trigger scheduler.
// rr_next mirrors the hardware selection rule for use by models and checkers.
package trigger_sched_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_CNT_WIDTH   = 8;
    localparam int DEF_DELTA_WIDTH = 2;
    localparam int DEF_IDX_WIDTH   = $clog2(DEF_NUM_REQ);

    typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;
    typedef logic [DEF_IDX_WIDTH-1:0] idx_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    // First set bit of mask strictly after ptr, wrapping; returns ptr when mask is empty.
    function automatic idx_t rr_next(input idx_t ptr, input logic [DEF_NUM_REQ-1:0] mask);
        idx_t res;
        int   j;
        res = ptr;
        for (int k = DEF_NUM_REQ; k >= 1; k--) begin
            j = (int'(ptr) + k) % DEF_NUM_REQ;
            if (mask[j]) begin
                res = idx_t'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/trigger_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of mask after ptr, with wrap-around.
// The mask is duplicated so the rotated window is a plain part-select.
module rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   mask,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx
);

    localparam logic [IDX_WIDTH:0] NUM_REQ_W = (IDX_WIDTH+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_WIDTH:0]   start;
    logic [IDX_WIDTH:0]   offset;
    logic [IDX_WIDTH:0]   sum;

    assign dbl = {mask, mask};

    always_comb begin
        start = {1'b0, ptr} + {{IDX_WIDTH{1'b0}}, 1'b1};
        if (start >= NUM_REQ_W) begin
            start = '0;
        end
        rot    = dbl[start +: NUM_REQ];
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = i[IDX_WIDTH:0];
            end
        end
        sum = start + offset;
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        idx   = sum[IDX_WIDTH-1:0];
        found = |mask;
    end

endmodule

// File: rtl/trigger_rr_scheduler.sv
// Per-source pending-event counters feeding a round-robin selector and a
// one-entry valid/ready grant stage. A grant is debited from its count when loaded.
module trigger_rr_scheduler
    import trigger_sched_pkg::*;
#(
    parameter int  NUM_REQ     = DEF_NUM_REQ,
    parameter int  CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int  DELTA_WIDTH = DEF_DELTA_WIDTH,
    localparam int IDX_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ*DELTA_WIDTH-1:0] req_delta,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           grant_valid,
    output logic [IDX_WIDTH-1:0]           grant_idx,
    output logic [NUM_REQ-1:0]             grant_onehot,
    input  logic                           grant_ready,
    output logic                           pending_any
);

    localparam int CNT_MAX   = 2**CNT_WIDTH - 1;
    localparam int DELTA_MAX = 2**DELTA_WIDTH - 1;
    localparam logic [CNT_WIDTH:0]   CNT_MAX_W   = (CNT_WIDTH+1)'(CNT_MAX);
    localparam logic [CNT_WIDTH-1:0] READY_LIMIT = CNT_WIDTH'(CNT_MAX - DELTA_MAX);
    localparam logic [IDX_WIDTH-1:0] PTR_RESET   = IDX_WIDTH'(NUM_REQ - 1);

    stage_t                            state_reg, state_next;
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] count_reg, count_next;
    logic [NUM_REQ-1:0][CNT_WIDTH:0]   avail;
    logic [NUM_REQ-1:0]                eligible;
    logic [NUM_REQ-1:0]                take;
    logic [NUM_REQ-1:0]                ready_next;
    logic [NUM_REQ-1:0]                req_ready_reg;
    logic [NUM_REQ-1:0]                grant_onehot_reg;
    logic [IDX_WIDTH-1:0]              rr_ptr_reg, grant_idx_reg, pick_idx;
    logic                              pick_found, load, pending_any_reg;

    // Same-cycle deltas are counted before eligibility, so a fresh event can be granted at once.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
            logic [CNT_WIDTH:0] remain;
            assign avail[gi]    = {1'b0, count_reg[gi]}
                                + (CNT_WIDTH+1)'(req_delta[gi*DELTA_WIDTH +: DELTA_WIDTH]);
            assign eligible[gi] = (avail[gi] != '0);
            assign take[gi]     = load && (pick_idx == IDX_WIDTH'(gi));
            assign remain       = avail[gi] - (CNT_WIDTH+1)'(take[gi]);
            assign count_next[gi] = (remain > CNT_MAX_W) ? CNT_WIDTH'(CNT_MAX)
                                                         : remain[CNT_WIDTH-1:0];
            assign ready_next[gi] = (count_next[gi] <= READY_LIMIT);
        end
    endgenerate

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_pick (
        .mask  (eligible),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign grant_valid = (state_reg == ST_FULL);
    assign load        = (!grant_valid || grant_ready) && pick_found;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (load) state_next = ST_FULL;
            ST_FULL:  if (grant_ready) state_next = load ? ST_FULL : ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_EMPTY;
            count_reg        <= '0;
            rr_ptr_reg       <= PTR_RESET;
            grant_idx_reg    <= '0;
            grant_onehot_reg <= '0;
            req_ready_reg    <= '1;
            pending_any_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            req_ready_reg   <= ready_next;
            pending_any_reg <= |count_next;
            if (load) begin
                rr_ptr_reg       <= pick_idx;
                grant_idx_reg    <= pick_idx;
                grant_onehot_reg <= NUM_REQ'(1) << pick_idx;
            end else if (grant_ready) begin
                grant_onehot_reg <= '0;
            end
        end
    end

    assign req_ready    = req_ready_reg;
    assign grant_idx    = grant_idx_reg;
    assign grant_onehot = grant_onehot_reg;
    assign pending_any  = pending_any_reg;

endmodule

// File: tb/tb_trigger_rr_scheduler.sv
// Randomised and directed bench for trigger_rr_scheduler against an event-count
// reference model; uses a 4-bit counter build so saturation is reachable quickly.
module tb_trigger_rr_scheduler;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int DW   = 2;
    localparam int CMAX = 15;
    localparam int DMAX = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*DW-1:0] req_delta;
    logic [N-1:0]   req_ready;
    logic           grant_valid;
    logic [1:0]     grant_idx;
    logic [N-1:0]   grant_onehot;
    logic           grant_ready;
    logic           pending_any;

    trigger_rr_scheduler #(
        .NUM_REQ     (N),
        .CNT_WIDTH   (CW),
        .DELTA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_delta    (req_delta),
        .req_ready    (req_ready),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .grant_ready  (grant_ready),
        .pending_any  (pending_any)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference state: pending events per source, presented grant, last granted source.
    int       m_cnt [N];
    bit       m_valid;
    int       m_idx;
    int       m_ptr;
    bit [N-1:0] m_onehot;
    bit [N-1:0] m_ready;
    bit       m_pend;

    int hs_total;
    int hs_src [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_valid  = 1'b0;
        m_idx    = 0;
        m_ptr    = N - 1;
        m_onehot = '0;
        m_ready  = '1;
        m_pend   = 1'b0;
    endtask

    task automatic model_step(input logic [N*DW-1:0] d, input logic gr);
        int avail [N];
        int pick;
        int nc;
        int j;
        bit load;
        for (int i = 0; i < N; i++) avail[i] = m_cnt[i] + int'(d[i*DW +: DW]);
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            j = (m_ptr + k) % N;
            if (pick < 0 && avail[j] > 0) pick = j;
        end
        load   = (!m_valid || gr) && (pick >= 0);
        m_pend = 1'b0;
        for (int i = 0; i < N; i++) begin
            nc = avail[i] - ((load && pick == i) ? 1 : 0);
            if (nc > CMAX) nc = CMAX;
            m_cnt[i]   = nc;
            m_ready[i] = (nc <= CMAX - DMAX);
            if (nc != 0) m_pend = 1'b1;
        end
        if (load) begin
            m_valid        = 1'b1;
            m_idx          = pick;
            m_onehot       = '0;
            m_onehot[pick] = 1'b1;
            m_ptr          = pick;
        end else if (gr) begin
            m_valid  = 1'b0;
            m_onehot = '0;
        end
    endtask

    // One clock of stimulus; outputs are compared 1 time unit after the edge.
    task automatic step(input logic [N*DW-1:0] d, input logic gr, input logic rn);
        if (rn && gr && grant_valid) begin
            hs_total++;
            hs_src[grant_idx]++;
        end
        req_delta   = d;
        grant_ready = gr;
        rst_n       = rn;
        if (!rn) model_reset();
        else     model_step(d, gr);
        @(posedge clk);
        #1;
        cyc++;
        check_eq("grant_valid",  32'(grant_valid),  32'(m_valid));
        check_eq("grant_idx",    32'(grant_idx),    32'(m_idx));
        check_eq("grant_onehot", 32'(grant_onehot), 32'(m_onehot));
        check_eq("req_ready",    32'(req_ready),    32'(m_ready));
        check_eq("pending_any",  32'(pending_any),  32'(m_pend));
        $display("cyc=%0d rst_n=%b delta=%h gready=%b -> valid=%b idx=%0d onehot=%b ready=%b pend=%b",
                 cyc, rn, d, gr, grant_valid, grant_idx, grant_onehot, req_ready, pending_any);
    endtask

    task automatic clear_hs();
        hs_total = 0;
        for (int i = 0; i < N; i++) hs_src[i] = 0;
    endtask

    initial begin
        logic [N*DW-1:0] d;
        logic            gr;
        logic            rn;

        clear_hs();
        req_delta   = '0;
        grant_ready = 1'b0;
        rst_n       = 1'b0;
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);

        // Basic grant from source 2.
        step(8'h10, 1'b1, 1'b1);
        check_eq("basic_valid", 32'(grant_valid), 32'd1);
        check_eq("basic_idx",   32'(grant_idx),   32'd2);
        step('0, 1'b1, 1'b1);
        check_eq("basic_empty", 32'(grant_valid), 32'd0);
        check_eq("basic_pend",  32'(pending_any), 32'd0);

        // Round-robin over four sources with three events each.
        step('0, 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b1);
        for (int n = 0; n < 12; n++) begin
            check_eq("rr_seq", 32'(grant_idx), 32'(n % N));
            step('0, 1'b1, 1'b1);
        end
        check_eq("rr_done", 32'(grant_valid), 32'd0);

        // Backpressure: the presented grant is held while source 1 accumulates.
        step('0, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            step(8'h04, 1'b0, 1'b1);
            check_eq("bp_hold", 32'(grant_idx), 32'd0);
        end
        clear_hs();
        for (int n = 0; n < 12; n++) step('0, 1'b1, 1'b1);
        check_eq("bp_src1", 32'(hs_src[1]), 32'd5);
        check_eq("bp_src0", 32'(hs_src[0]), 32'd1);

        // Saturation on source 0, then drain the clamped count.
        step('0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            step(8'h03, 1'b0, 1'b1);
            if (n == 3) check_eq("sat_ready_hi", 32'(req_ready[0]), 32'd1);
        end
        check_eq("sat_ready_lo", 32'(req_ready[0]), 32'd0);
        for (int n = 0; n < 3; n++) step(8'h03, 1'b0, 1'b1);
        clear_hs();
        for (int n = 0; n < 20; n++) step('0, 1'b1, 1'b1);
        check_eq("sat_drain", 32'(hs_total), 32'd16);

        // Reset while a grant is presented and counts are nonzero.
        step(8'hAA, 1'b0, 1'b1);
        step(8'hAA, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0);
        check_eq("mrst_valid", 32'(grant_valid), 32'd0);
        check_eq("mrst_pend",  32'(pending_any), 32'd0);
        step(8'hFF, 1'b1, 1'b1);
        check_eq("mrst_prio",  32'(grant_idx),   32'd0);

        // Same-cycle bypass for sources 1 and 3.
        step('0, 1'b0, 1'b0);
        step(8'h44, 1'b1, 1'b1);
        check_eq("byp_first",  32'(grant_idx),   32'd1);
        step('0, 1'b1, 1'b1);
        check_eq("byp_second", 32'(grant_idx),   32'd3);
        check_eq("byp_pend",   32'(pending_any), 32'd0);
        step('0, 1'b1, 1'b1);
        check_eq("byp_empty",  32'(grant_valid), 32'd0);

        // Random traffic respecting req_ready, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (m_ready[i] && $urandom_range(0, 2) == 0)
                    d[i*DW +: DW] = 2'($urandom_range(0, 3));
            end
            gr = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 99) != 0);
            step(d, gr, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
